// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler: busy scoreboard with issue stall, round-robin
// arbitration between pipeline writeback (A) and multi-cycle unit (B), registered write port.
module regfile_wb_scheduler #(
  parameter int NREG  = 32,
  parameter int WIDTH = 32,
  localparam int IW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [IW-1:0]    issue_rs1,
  input  logic [IW-1:0]    issue_rs2,
  input  logic [IW-1:0]    issue_rd,
  input  logic             issue_wr,
  output logic             stall,
  input  logic             a_valid,
  input  logic [IW-1:0]    a_reg,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [IW-1:0]    b_reg,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             reg_write,
  output logic [IW-1:0]    write_reg,
  output logic [WIDTH-1:0] write_data,
  output logic [NREG-1:0]  busy_vec,
  output logic             wb_err
);

  typedef struct packed {
    logic [IW-1:0]    rg;
    logic [WIDTH-1:0] data;
  } wb_req_t;

  logic [NREG-1:0] busy, busy_nxt;
  logic            last_b;     // 1: B held the most recent grant
  logic            grant_a, grant_b, xfer, issue_set;
  wb_req_t         sel;

  assign busy_vec = busy;

  always_comb begin
    // Busy is the registered value only; a bit clearing this edge still stalls.
    stall     = issue_valid & (~rst_n | busy[issue_rs1] | busy[issue_rs2] |
                               (issue_wr & busy[issue_rd]));
    grant_a   = rst_n & a_valid & (~b_valid | last_b);
    grant_b   = rst_n & b_valid & (~a_valid | ~last_b);
    xfer      = grant_a | grant_b;
    sel       = grant_a ? '{rg: a_reg, data: a_data} : '{rg: b_reg, data: b_data};
    issue_set = issue_valid & ~stall & issue_wr & (issue_rd != '0);
    busy_nxt  = busy;
    if (reg_write) busy_nxt[write_reg] = 1'b0;
    if (issue_set) busy_nxt[issue_rd]  = 1'b1;   // set wins over a same-edge clear
    busy_nxt[0] = 1'b0;
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy       <= '0;
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      wb_err     <= 1'b0;
      last_b     <= 1'b1;
    end else begin
      busy      <= busy_nxt;
      reg_write <= xfer & (sel.rg != '0);
      if (xfer) begin
        write_reg  <= sel.rg;
        write_data <= sel.data;
        last_b     <= grant_b;
        if (!busy[sel.rg]) wb_err <= 1'b1;
      end
    end
  end

endmodule
